// File: rtl/ysyx_24110006_mem_arbiter.sv
// Memory-port arbiter between the IFU (read-only) and the LSU (read/write).
// One transaction is outstanding at a time: the granted request is latched,
// presented downstream, and the response is routed back to its owner as a
// one-cycle pulse. A downstream hang is turned into an error response after
// TIMEOUT cycles in RESP; the late response is then drained and discarded.
//
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   ifu_req_* / ifu_rsp_* IFU fetch request (word read) and response pulse
//   lsu_req_* / lsu_rsp_* LSU load/store request and response pulse
//   mem_req_* / mem_rsp_* downstream request (held until ready) and response
module ysyx_24110006_mem_arbiter #(
  parameter bit          LSU_PRIO = 1'b1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_write,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_strb,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_strb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDrain} state_e;

  state_e          state_q;
  // 1 = LSU. Holds the last winner, which is also the owner of the
  // in-flight transaction, so one register serves both purposes.
  logic            rr_last_q;
  logic [CntW-1:0] cnt_q;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        timeout_hit;
  logic        fin_err;
  logic [31:0] fin_data;

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == StIdle) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (LSU_PRIO || !rr_last_q) grant_lsu = 1'b1;
        else                        grant_ifu = 1'b1;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  // Readies are masked by reset so every output is low while reset is held.
  assign ifu_req_ready = grant_ifu & reset;
  assign lsu_req_ready = grant_lsu & reset;
  assign mem_req_valid = (state_q == StReq);

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  // A real response wins over a timeout landing in the same cycle.
  assign fin_err  = !mem_rsp_valid || mem_rsp_err;
  assign fin_data = (!mem_rsp_valid || mem_req_write) ? 32'h0 : mem_rsp_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      rr_last_q     <= 1'b0;
      cnt_q         <= '0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= 32'h0;
      mem_req_wdata <= 32'h0;
      mem_req_strb  <= 4'h0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= 32'h0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= 32'h0;
      lsu_rsp_err   <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_ifu || grant_lsu) begin
            rr_last_q     <= grant_lsu;
            mem_req_write <= grant_lsu & lsu_req_write;
            mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
            mem_req_wdata <= grant_lsu ? lsu_req_wdata : 32'h0;
            mem_req_strb  <= grant_lsu ? lsu_req_strb : 4'hf;
            state_q       <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (mem_rsp_valid || timeout_hit) begin
            if (rr_last_q) begin
              lsu_rsp_valid <= 1'b1;
              lsu_rsp_data  <= fin_data;
              lsu_rsp_err   <= fin_err;
            end else begin
              ifu_rsp_valid <= 1'b1;
              ifu_rsp_data  <= fin_data;
              ifu_rsp_err   <= fin_err;
            end
            state_q <= mem_rsp_valid ? StIdle : StDrain;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrain: begin
          // Swallow the late response of a timed-out transaction.
          if (mem_rsp_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
module tb_ysyx_24110006_mem_arbiter;

  localparam bit MainPrio = 1'b0;

  logic clock, reset;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic lsu_req_valid, lsu_req_ready, lsu_req_write, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [3:0] lsu_req_strb;
  logic mem_req_valid, mem_req_ready, mem_req_write, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0] mem_req_strb;

  logic p_ifu_req_valid, p_ifu_req_ready, p_ifu_rsp_valid, p_ifu_rsp_err;
  logic [31:0] p_ifu_req_addr, p_ifu_rsp_data;
  logic p_lsu_req_valid, p_lsu_req_ready, p_lsu_req_write, p_lsu_rsp_valid, p_lsu_rsp_err;
  logic [31:0] p_lsu_req_addr, p_lsu_req_wdata, p_lsu_rsp_data;
  logic [3:0] p_lsu_req_strb;
  logic p_mem_req_valid, p_mem_req_ready, p_mem_req_write, p_mem_rsp_valid, p_mem_rsp_err;
  logic [31:0] p_mem_req_addr, p_mem_req_wdata, p_mem_rsp_data;
  logic [3:0] p_mem_req_strb;

  int n_vec = 0;
  int n_err = 0;
  bit m_last_lsu = 1'b0;  // reference: last winner was the LSU

  ysyx_24110006_mem_arbiter #(.LSU_PRIO(MainPrio), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_write(lsu_req_write),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_strb(lsu_req_strb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_strb(mem_req_strb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );

  ysyx_24110006_mem_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT(8)) dut_p (
    .clock(clock), .reset(reset),
    .ifu_req_valid(p_ifu_req_valid), .ifu_req_ready(p_ifu_req_ready),
    .ifu_req_addr(p_ifu_req_addr), .ifu_rsp_valid(p_ifu_rsp_valid),
    .ifu_rsp_data(p_ifu_rsp_data), .ifu_rsp_err(p_ifu_rsp_err),
    .lsu_req_valid(p_lsu_req_valid), .lsu_req_ready(p_lsu_req_ready),
    .lsu_req_write(p_lsu_req_write), .lsu_req_addr(p_lsu_req_addr),
    .lsu_req_wdata(p_lsu_req_wdata), .lsu_req_strb(p_lsu_req_strb),
    .lsu_rsp_valid(p_lsu_rsp_valid), .lsu_rsp_data(p_lsu_rsp_data), .lsu_rsp_err(p_lsu_rsp_err),
    .mem_req_valid(p_mem_req_valid), .mem_req_ready(p_mem_req_ready),
    .mem_req_write(p_mem_req_write), .mem_req_addr(p_mem_req_addr),
    .mem_req_wdata(p_mem_req_wdata), .mem_req_strb(p_mem_req_strb),
    .mem_rsp_valid(p_mem_rsp_valid), .mem_rsp_data(p_mem_rsp_data), .mem_rsp_err(p_mem_rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // One full transaction from request to response pulse, checked cycle by cycle.
  task automatic do_txn(input bit iv, input bit lv, input bit wr, input logic [31:0] ia,
                        input logic [31:0] la, input logic [31:0] wd, input logic [3:0] st,
                        input int req_wait, input int rsp_wait, input bit merr,
                        input logic [31:0] rdata, output bit won_lsu);
    bit exp_lsu, exp_ifu, e_wr, got_err;
    logic [31:0] e_addr, got_data, e_data;
    logic [3:0] e_st;
    @(negedge clock);
    ifu_req_valid = iv; ifu_req_addr = ia;
    lsu_req_valid = lv; lsu_req_write = wr; lsu_req_addr = la;
    lsu_req_wdata = wd; lsu_req_strb = st;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom_range(0, 1));
    #1;
    exp_lsu = lv && (!iv || MainPrio || !m_last_lsu);
    exp_ifu = iv && !exp_lsu;
    n_vec++;
    if (ifu_req_ready !== exp_ifu) begin
      n_err++; $display("FAIL ifu_req_ready: got %b want %b", ifu_req_ready, exp_ifu);
    end
    n_vec++;
    if (lsu_req_ready !== exp_lsu) begin
      n_err++; $display("FAIL lsu_req_ready: got %b want %b", lsu_req_ready, exp_lsu);
    end
    n_vec++;
    if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin
      n_err++; $display("FAIL idle_quiet: got %b want 000",
                        {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid});
    end
    m_last_lsu = exp_lsu;
    won_lsu = exp_lsu;
    e_wr = exp_lsu && wr;
    e_addr = exp_lsu ? la : ia;
    e_st = exp_lsu ? st : 4'hf;
    for (int i = 0; i <= req_wait; i++) begin
      @(negedge clock);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      mem_req_ready = (i == req_wait);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_strb} !==
          {1'b1, e_wr, e_addr, e_st}) begin
        n_err++; $display("FAIL mem_req: got v%b w%b a%h s%h want v1 w%b a%h s%h",
                          mem_req_valid, mem_req_write, mem_req_addr, mem_req_strb,
                          e_wr, e_addr, e_st);
      end
      if (exp_lsu) begin
        n_vec++;
        if (mem_req_wdata !== wd) begin
          n_err++; $display("FAIL mem_req_wdata: got %h want %h", mem_req_wdata, wd);
        end
      end
    end
    for (int i = 0; i <= rsp_wait; i++) begin
      @(negedge clock);
      mem_req_ready = 1'b0;
      mem_rsp_valid = (i == rsp_wait);
      mem_rsp_data = rdata; mem_rsp_err = merr;
      #1;
      n_vec++;
      if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin
        n_err++; $display("FAIL resp_wait: got %b want 000",
                          {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid});
      end
    end
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    #1;
    n_vec++;
    if ({ifu_rsp_valid, lsu_rsp_valid} !== {!exp_lsu, exp_lsu}) begin
      n_err++; $display("FAIL rsp_route: got %b want %b", {ifu_rsp_valid, lsu_rsp_valid},
                        {!exp_lsu, exp_lsu});
    end
    got_err = exp_lsu ? lsu_rsp_err : ifu_rsp_err;
    got_data = exp_lsu ? lsu_rsp_data : ifu_rsp_data;
    e_data = e_wr ? 32'h0 : rdata;
    n_vec++;
    if (got_err !== merr) begin
      n_err++; $display("FAIL rsp_err: got %b want %b", got_err, merr);
    end
    if (!merr) begin
      n_vec++;
      if (got_data !== e_data) begin
        n_err++; $display("FAIL rsp_data: got %h want %h", got_data, e_data);
      end
    end
  endtask

  task automatic test_reset();
    logic [114:0] outs;
    reset = 1'b0;
    {ifu_req_valid, lsu_req_valid, lsu_req_write, mem_req_ready, mem_rsp_valid, mem_rsp_err} = '0;
    ifu_req_addr = '0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_strb = '0;
    mem_rsp_data = '0;
    {p_ifu_req_valid, p_lsu_req_valid, p_lsu_req_write, p_mem_req_ready} = '0;
    {p_mem_rsp_valid, p_mem_rsp_err} = '0;
    p_ifu_req_addr = 32'h100; p_lsu_req_addr = 32'h200; p_lsu_req_wdata = '0;
    p_lsu_req_strb = 4'hf; p_mem_rsp_data = 32'h55;
    repeat (2) @(negedge clock);
    #1;
    outs = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_req_ready,
            lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err, mem_req_valid, mem_req_write,
            mem_req_addr, mem_req_wdata[15:0], mem_req_strb};
    n_vec++;
    if (outs !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    n_vec++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {ifu_req_ready, lsu_req_ready});
    end
    @(negedge clock);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    reset = 1'b1;
    m_last_lsu = 1'b0;
  endtask

  task automatic test_ifu_fetch();
    bit w;
    do_txn(1'b1, 1'b0, 1'b0, 32'h3000_0000, 32'h0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0000_0413, w);
  endtask

  task automatic test_store_wait();
    bit w;
    do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0f00_0004, 32'hdead_beef, 4'b1100, 2, 0, 1'b0,
           32'h1234_5678, w);
  endtask

  task automatic test_round_robin();
    bit w[4];
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, 1'b0, 32'h3000_0000 + 32'(i * 4), 32'h8000_0000 + 32'(i * 4),
             32'h0, 4'hf, 0, 0, 1'b0, $urandom, w[i]);
    for (int i = 1; i < 4; i++) begin
      n_vec++;
      if (w[i] == w[i-1]) begin
        n_err++; $display("FAIL rr_alternate: got same winner %b twice want alternating", w[i]);
      end
    end
  endtask

  task automatic test_bus_error();
    bit w;
    do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0a00_0010, 32'h0, 4'b0011, 1, 2, 1'b1, 32'hffff, w);
    do_txn(1'b1, 1'b0, 1'b0, 32'h3000_0040, 32'h0, 32'h0, 4'h0, 0, 1, 1'b0, 32'h0000_0013, w);
  endtask

  task automatic test_timeout();
    int got;
    bit e_err, bad_grant;
    logic [31:0] e_data;
    bit w;
    got = -1; e_err = 1'b0; e_data = 32'hx; bad_grant = 1'b0;
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h0200_0000;
    lsu_req_strb = 4'hf; ifu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    n_vec++;
    if (lsu_req_ready !== 1'b1) begin
      n_err++; $display("FAIL to_accept: got %b want 1", lsu_req_ready);
    end
    m_last_lsu = 1'b1;
    @(negedge clock);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0; ifu_req_valid = 1'b1;
    for (int k = 0; k < 16 && got < 0; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      bad_grant |= ifu_req_ready;
      if (lsu_rsp_valid) begin
        got = k; e_err = lsu_rsp_err; e_data = lsu_rsp_data;
      end
    end
    n_vec++;
    if (got != 9) begin
      n_err++; $display("FAIL to_latency: got %0d want 9", got);
    end
    n_vec++;
    if ({e_err, e_data} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL to_rsp: got err %b data %h want err 1 data 0", e_err, e_data);
    end
    repeat (2) begin
      @(negedge clock);
      #1;
      bad_grant |= ifu_req_ready | ifu_rsp_valid | lsu_rsp_valid;
    end
    @(negedge clock);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hbad0_0000; mem_rsp_err = 1'b0;
    #1;
    bad_grant |= ifu_req_ready;
    n_vec++;
    if (bad_grant) begin
      n_err++; $display("FAIL drain_block: got grant or pulse want none");
    end
    @(negedge clock);
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b0;
    #1;
    n_vec++;
    if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
      n_err++; $display("FAIL drain_swallow: got %b want 00", {ifu_rsp_valid, lsu_rsp_valid});
    end
    do_txn(1'b1, 1'b0, 1'b0, 32'h3000_0080, 32'h0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0000_0093, w);
  endtask

  task automatic test_timeout_race();
    bit w;
    do_txn(1'b1, 1'b0, 1'b0, 32'h3000_00c0, 32'h0, 32'h0, 4'h0, 0, 8, 1'b0, 32'h1111_2222, w);
  endtask

  task automatic test_prio();
    int lg, ig, rp;
    lg = 0; ig = 0; rp = 0;
    @(negedge clock);
    p_ifu_req_valid = 1'b1; p_lsu_req_valid = 1'b1;
    p_mem_req_ready = 1'b1; p_mem_rsp_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      lg += int'(p_lsu_req_ready); ig += int'(p_ifu_req_ready); rp += int'(p_lsu_rsp_valid);
    end
    n_vec++;
    if (lg != 4 || ig != 0) begin
      n_err++; $display("FAIL prio_grants: got lsu %0d ifu %0d want lsu 4 ifu 0", lg, ig);
    end
    n_vec++;
    if (rp != 3) begin
      n_err++; $display("FAIL prio_rsp: got %0d pulses want 3", rp);
    end
    @(negedge clock);
    p_lsu_req_valid = 1'b0;
    #1;
    n_vec++;
    if (p_ifu_req_ready !== 1'b1) begin
      n_err++; $display("FAIL prio_ifu_alone: got %b want 1", p_ifu_req_ready);
    end
    @(negedge clock);
    p_ifu_req_valid = 1'b0;
  endtask

  task automatic test_random();
    bit iv, lv, w;
    for (int t = 0; t < 40; t++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) lv = 1'b1;
      do_txn(iv, lv, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 8),
             ($urandom_range(0, 7) == 0), $urandom, w);
    end
  endtask

  task automatic test_reset_mid();
    logic [114:0] outs;
    bit w;
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_req_write = 1'b1; lsu_req_addr = 32'h0f00_0100;
    lsu_req_wdata = 32'hcafe_f00d; lsu_req_strb = 4'hf; ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    outs = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_req_ready,
            lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err, mem_req_valid, mem_req_write,
            mem_req_addr, mem_req_wdata[15:0], mem_req_strb};
    n_vec++;
    if (outs !== '0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", outs);
    end
    @(negedge clock);
    mem_rsp_valid = 1'b1;
    @(negedge clock);
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    reset = 1'b1;
    m_last_lsu = 1'b0;
    repeat (3) begin
      @(negedge clock);
      #1;
      n_vec++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
        n_err++; $display("FAIL reset_no_rsp: got %b want 00", {ifu_rsp_valid, lsu_rsp_valid});
      end
    end
    do_txn(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0f00_0008, 32'h0, 4'hf, 0, 0, 1'b0,
           32'h7777_0000, w);
    n_vec++;
    if (w !== 1'b1) begin
      n_err++; $display("FAIL reset_first_tie: got %b want 1 (LSU)", w);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_store_wait();
    test_round_robin();
    test_bus_error();
    test_timeout();
    test_timeout_race();
    test_prio();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
